prach_hb_dec: RTL

Parametrised multi-channel half-band decimator for the PRACH long-sequence chain. Takes two polyphase TDM streams per valid cycle, one sample per channel, and produces one filtered TDM output sample:
- `din_dp1` is the centre-tap phase.
- `din_dp2` is the odd-tap phase.

Generalises the fixed 32-channel, 2-coefficient stage with the following:
- configurable channel count, tap count and widths;
- a valid-gated history, so bubbles in `din_dv` are tolerated;
- convergent-free round-half-up output;
- channel-sequence checking.

---
 rtl/prach_hb_pkg.sv | 32 +++
 rtl/prach_hb_if.sv | 28 ++
 rtl/prach_hb_dec_hist.sv | 35 +++
 rtl/prach_hb_dec.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/prach_hb_pkg.sv
// Shared types, default coefficients and helper functions for the PRACH half-band decimator.
package prach_hb_pkg;

    localparam int unsigned CHN_W            = 8;
    localparam int unsigned DEF_NUM_CHANNEL  = 32;
    localparam int unsigned DEF_NUM_UNIQ_COE = 2;
    localparam int unsigned DEF_DATA_W       = 16;
    localparam int unsigned DEF_COE_W        = 18;

    typedef logic signed [DEF_COE_W-1:0] coe_t;

    // COE[0] is the outermost symmetric pair, COE[N-1] the innermost
    localparam coe_t DEF_COE [DEF_NUM_UNIQ_COE] = '{-18'sd4249, 18'sd37013};

    // Sideband carried alongside the datapath
    typedef struct packed {
        logic             sync;
        logic             dv;
        logic [CHN_W-1:0] chn;
    } ctl_t;

    // Input-valid to output-valid latency in cycles
    function automatic int unsigned hb_latency(input int n);
        return 5 + $clog2(n);
    endfunction

    // Half-LSB of the output after the final (COE_W-1) arithmetic shift
    function automatic longint unsigned hb_round_const(input int unsigned coe_w);
        return 64'd1 << (coe_w - 2);
    endfunction

endpackage

// File: rtl/prach_hb_if.sv
// TDM sample bus into and out of the half-band decimator.
interface prach_hb_if
    import prach_hb_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic signed [DATA_W-1:0] din_dp1;
    logic signed [DATA_W-1:0] din_dp2;
    logic                     din_dv;
    logic [CHN_W-1:0]         din_chn;
    logic                     sync_in;

    logic signed [DATA_W-1:0] dout_dq;
    logic                     dout_dv;
    logic [CHN_W-1:0]         dout_chn;
    logic                     sync_out;
    logic                     err_chn;

    modport master (
        output din_dp1, din_dp2, din_dv, din_chn, sync_in,
        input  dout_dq, dout_dv, dout_chn, sync_out, err_chn
    );

    modport slave (
        input  din_dp1, din_dp2, din_dv, din_chn, sync_in,
        output dout_dq, dout_dv, dout_chn, sync_out, err_chn
    );
endinterface

// File: rtl/prach_hb_dec_hist.sv
// Valid-gated TDM history line: tap k is the same channel's sample k frames old.
module prach_tdm_hist #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned NUM_CHANNEL = 32,
    parameter int unsigned FIRST_TAP   = 0
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_taps [DEPTH/NUM_CHANNEL - FIRST_TAP + 1]
);
    localparam int unsigned NTAP = DEPTH/NUM_CHANNEL - FIRST_TAP + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Shift only on valid samples so idle cycles never age the history
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    for (genvar k = 0; k < NTAP; k++) begin : g_tap
        if (FIRST_TAP + k == 0) begin : g_cur
            assign o_taps[k] = i_din;
        end else begin : g_old
            assign o_taps[k] = r_mem[(FIRST_TAP + k) * NUM_CHANNEL - 1];
        end
    end

endmodule

// File: rtl/prach_hb_dec.sv
// Multi-channel TDM half-band decimator with round-half-up output and channel-sequence check.
// Optional feature macro: PRACH_HB_SAT_EN (clamp output instead of two's-complement wrap).
module prach_hb_dec
    import prach_hb_pkg::*;
#(
    parameter int unsigned NUM_CHANNEL  = DEF_NUM_CHANNEL,
    parameter int unsigned NUM_UNIQ_COE = DEF_NUM_UNIQ_COE,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned COE_W        = DEF_COE_W,
    parameter logic signed [COE_W-1:0] COE [NUM_UNIQ_COE] = DEF_COE
) (
    input  logic      clk,
    input  logic      rst_n,
    prach_hb_if.slave bus
);
    localparam int unsigned N     = NUM_UNIQ_COE;
    localparam int unsigned L     = $clog2(N);
    localparam int unsigned NP2   = 1 << L;
    localparam int unsigned NODE  = 2 * NP2 - 1;
    localparam int unsigned LAT   = hb_latency(N);
    localparam int unsigned PRE_W = DATA_W + 1;
    localparam int unsigned ACC_W = COE_W + DATA_W + L + 3;
    localparam logic signed [ACC_W-1:0] RND = ACC_W'(hb_round_const(COE_W));

    logic [DATA_W-1:0]        w_tap1 [1];
    logic [DATA_W-1:0]        w_tap2 [2*N];

    logic [DATA_W-1:0]        r_tap2 [2*N];
    logic [DATA_W-1:0]        r_ctr1;
    logic signed [PRE_W-1:0]  r_pre  [N];
    logic [DATA_W-1:0]        r_ctr2;
    logic signed [ACC_W-1:0]  r_node [NODE];
    logic [DATA_W-1:0]        r_ctr3 [L+1];
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [DATA_W-1:0] w_dq;
    logic signed [DATA_W-1:0] r_dq;

    ctl_t                     w_ctl;
    ctl_t                     r_ctl  [LAT];

    logic [CHN_W-1:0]         w_exp;
    logic                     w_mis;
    logic [CHN_W-1:0]         r_exp;
    logic                     r_err;

    // Centre phase needs only the sample N frames old
    prach_tdm_hist #(
        .WIDTH       (DATA_W),
        .DEPTH       (N * NUM_CHANNEL),
        .NUM_CHANNEL (NUM_CHANNEL),
        .FIRST_TAP   (N)
    ) u_hist_dp1 (
        .clk    (clk),
        .i_en   (bus.din_dv),
        .i_din  (bus.din_dp1),
        .o_taps (w_tap1)
    );

    // Odd phase exposes taps 0 .. 2N-1
    prach_tdm_hist #(
        .WIDTH       (DATA_W),
        .DEPTH       ((2 * N - 1) * NUM_CHANNEL),
        .NUM_CHANNEL (NUM_CHANNEL),
        .FIRST_TAP   (0)
    ) u_hist_dp2 (
        .clk    (clk),
        .i_en   (bus.din_dv),
        .i_din  (bus.din_dp2),
        .o_taps (w_tap2)
    );

    // Datapath: tap register, pre-add, multiply, adder tree, centre add + round
    always_ff @(posedge clk) begin
        for (int j = 0; j < 2 * N; j++) begin
            r_tap2[j] <= w_tap2[j];
        end
        r_ctr1 <= w_tap1[0];

        for (int j = 0; j < N; j++) begin
            r_pre[j] <= PRE_W'($signed(r_tap2[j])) + PRE_W'($signed(r_tap2[2*N-1-j]));
        end
        r_ctr2 <= r_ctr1;

        for (int j = 0; j < N; j++) begin
            r_node[NP2-1+j] <= ACC_W'(r_pre[j]) * ACC_W'(COE[j]);
        end
        for (int j = N; j < NP2; j++) begin
            r_node[NP2-1+j] <= '0;
        end
        r_ctr3[0] <= r_ctr2;

        for (int i = 0; i < NP2 - 1; i++) begin
            r_node[i] <= r_node[2*i+1] + r_node[2*i+2];
        end
        for (int k = 1; k <= L; k++) begin
            r_ctr3[k] <= r_ctr3[k-1];
        end

        r_acc <= r_node[0] + (ACC_W'($signed(r_ctr3[L])) <<< (COE_W - 2)) + RND;
    end

`ifdef PRACH_HB_SAT_EN
    localparam logic signed [ACC_W-1:0] Y_MAX = (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] Y_MIN = -(ACC_W'(1) <<< (DATA_W - 1));

    logic signed [ACC_W-1:0] w_y;

    // Scale back to sample units and clamp to the DATA_W range
    always_comb begin
        w_y  = r_acc >>> (COE_W - 1);
        w_dq = DATA_W'(w_y);
        if (w_y > Y_MAX) begin
            w_dq = DATA_W'(Y_MAX);
        end else if (w_y < Y_MIN) begin
            w_dq = DATA_W'(Y_MIN);
        end
    end
`else
    // Scale back to sample units and wrap to DATA_W bits
    always_comb begin
        w_dq = DATA_W'(r_acc >>> (COE_W - 1));
    end
`endif

    // Sideband entering the delay line; sync is only meaningful with valid
    always_comb begin
        w_ctl      = '0;
        w_ctl.sync = bus.sync_in & bus.din_dv;
        w_ctl.dv   = bus.din_dv;
        w_ctl.chn  = bus.din_chn;
    end

    // Sideband delay line, LAT deep, aligned with the datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) begin
                r_ctl[k] <= '0;
            end
        end else begin
            r_ctl[0] <= w_ctl;
            for (int k = 1; k < LAT; k++) begin
                r_ctl[k] <= r_ctl[k-1];
            end
        end
    end

    // Output sample register, holds between valid outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dq <= '0;
        end else if (r_ctl[LAT-2].dv) begin
            r_dq <= w_dq;
        end
    end

    // Expected channel for the current input; sync realigns to channel 0
    always_comb begin
        w_exp = bus.sync_in ? '0 : r_exp;
        w_mis = bus.din_dv && (bus.din_chn != w_exp);
    end

    // Expected-channel counter and sticky sequence error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exp <= '0;
            r_err <= 1'b0;
        end else if (bus.din_dv) begin
            r_exp <= (w_exp == CHN_W'(NUM_CHANNEL - 1)) ? '0 : w_exp + CHN_W'(1);
            r_err <= r_err | w_mis;
        end
    end

    assign bus.dout_dq  = r_dq;
    assign bus.dout_dv  = r_ctl[LAT-1].dv;
    assign bus.dout_chn = r_ctl[LAT-1].chn;
    assign bus.sync_out = r_ctl[LAT-1].sync;
    assign bus.err_chn  = r_err;

endmodule
